uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_master.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: turns a register read/write request into an ASCII command
// line for a UART transmitter, then parses the device's one-line reply from
// the UART receiver and returns a one-cycle response with status and read data.
//
// Handshake: a request is accepted on any clock edge where req_valid and
// req_ready are both 1. req_ready is high only while idle. The requester must
// hold req_write/req_addr/req_data stable while req_valid is high. They are
// sampled once, at the accepting edge. The response is a single-cycle
// rsp_valid pulse with no back-pressure. rsp_status/rsp_data stay stable
// until the next response.
module uart_cmd_master #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        s_clk_50m,
  input  logic        s_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_TX = 3'd2,
    RECV    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0]  CH_CR = 8'h0D;
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_SP = 8'h20;
  localparam logic [7:0]  CH_W  = 8'h57;
  localparam logic [7:0]  CH_R  = 8'h52;

  // "FAIL" and "OK" as packed ASCII, oldest character in the top byte
  localparam logic [31:0] LINE_FAIL = 32'h4641_494C;
  localparam logic [15:0] LINE_OK   = 16'h4F4B;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_FAIL    = 2'd1;
  localparam logic [1:0]  ST_TIMEOUT = 2'd2;
  localparam logic [1:0]  ST_PROTO   = 2'd3;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  // Current FSM state. Its name is kept stable so checkers can bind to it.
  state_t      state;
  state_t      state_nxt;

  // latched command
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;

  // transmit sequencing
  logic [3:0]  byte_idx;
  logic [3:0]  last_idx;
  logic        wait_first;
  logic [7:0]  frame_byte;
  logic [3:0]  data_nib;

  // reply parser
  logic [31:0] to_cnt;
  logic [31:0] acc;
  logic [31:0] line_tail;
  logic [3:0]  line_len;
  logic        line_all_hex;
  logic        rx_hex_ok;
  logic [3:0]  rx_nib;
  logic [1:0]  line_status;
  logic [31:0] line_data;

  // decoded events
  logic        accept;
  logic        tx_fire;
  logic        tx_done;
  logic        rx_take;
  logic        rx_is_cr;
  logic        rx_is_lf;
  logic        line_end;
  logic        timeout_hit;

  function automatic logic [7:0] nib_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  assign accept      = (state == IDLE) && req_valid;
  assign last_idx    = cmd_write ? 4'd14 : 4'd5;
  assign tx_fire     = (state == SEND) && !tx_busy;
  assign tx_done     = (state == WAIT_TX) && !wait_first && !tx_busy;
  assign rx_take     = (state == RECV) && rx_done;
  assign rx_is_cr    = (rx_data == CH_CR);
  assign rx_is_lf    = (rx_data == CH_LF);
  assign line_end    = rx_take && rx_is_lf && (line_len != 4'd0);
  assign timeout_hit = (state == RECV) && (to_cnt == TO_LAST);

  // Data nibble for write-frame bytes 5..12, most significant first.
  always_comb begin
    data_nib = 4'h0;
    case (byte_idx)
      4'd5:    data_nib = cmd_data[31:28];
      4'd6:    data_nib = cmd_data[27:24];
      4'd7:    data_nib = cmd_data[23:20];
      4'd8:    data_nib = cmd_data[19:16];
      4'd9:    data_nib = cmd_data[15:12];
      4'd10:   data_nib = cmd_data[11:8];
      4'd11:   data_nib = cmd_data[7:4];
      4'd12:   data_nib = cmd_data[3:0];
      default: data_nib = 4'h0;
    endcase
  end

  // Byte of the command frame selected by byte_idx.
  always_comb begin
    frame_byte = 8'h00;
    if (cmd_write) begin
      case (byte_idx)
        4'd0:    frame_byte = CH_W;
        4'd1:    frame_byte = CH_SP;
        4'd2:    frame_byte = nib_ascii(cmd_addr[7:4]);
        4'd3:    frame_byte = nib_ascii(cmd_addr[3:0]);
        4'd4:    frame_byte = CH_SP;
        4'd13:   frame_byte = CH_CR;
        4'd14:   frame_byte = CH_LF;
        4'd15:   frame_byte = 8'h00;
        default: frame_byte = nib_ascii(data_nib);
      endcase
    end else begin
      case (byte_idx)
        4'd0:    frame_byte = CH_R;
        4'd1:    frame_byte = CH_SP;
        4'd2:    frame_byte = nib_ascii(cmd_addr[7:4]);
        4'd3:    frame_byte = nib_ascii(cmd_addr[3:0]);
        4'd4:    frame_byte = CH_CR;
        4'd5:    frame_byte = CH_LF;
        default: frame_byte = 8'h00;
      endcase
    end
  end

  // Decode an ASCII hex digit of either case into its nibble value.
  always_comb begin
    rx_hex_ok = 1'b0;
    rx_nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      rx_hex_ok = 1'b1;
      rx_nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      rx_hex_ok = 1'b1;
      rx_nib    = rx_data[3:0] + 4'd9;
    end
  end

  // Classify the terminated line. FAIL outranks everything else.
  always_comb begin
    line_status = ST_PROTO;
    line_data   = 32'h0;
    if (line_len == 4'd4 && line_tail == LINE_FAIL) begin
      line_status = ST_FAIL;
    end else if (cmd_write && line_len == 4'd2 && line_tail[15:0] == LINE_OK) begin
      line_status = ST_OK;
    end else if (!cmd_write && line_len == 4'd8 && line_all_hex) begin
      line_status = ST_OK;
      line_data   = acc;
    end
  end

  // State register. Reset abandons any frame in progress.
  always_ff @(posedge s_clk_50m or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the per-state outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SEND;
      end
      SEND: begin
        tx_data = frame_byte;
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) state_nxt = (byte_idx == last_idx) ? RECV : SEND;
      end
      RECV: begin
        // timeout is checked first so it wins over a simultaneous LF
        if (timeout_hit || line_end) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and transmit byte sequencing.
  always_ff @(posedge s_clk_50m or posedge s_rst) begin
    if (s_rst) begin
      cmd_write  <= 1'b0;
      cmd_addr   <= 8'h00;
      cmd_data   <= 32'h0;
      byte_idx   <= 4'd0;
      wait_first <= 1'b0;
    end else begin
      if (accept) begin
        cmd_write <= req_write;
        cmd_addr  <= req_addr;
        cmd_data  <= req_data;
        byte_idx  <= 4'd0;
      end
      if (tx_fire) wait_first <= 1'b1;
      else if (state == WAIT_TX) wait_first <= 1'b0;
      if (tx_done && byte_idx != last_idx) byte_idx <= byte_idx + 4'd1;
    end
  end

  // Reply parser and timeout counter. The counter runs from RECV entry only.
  always_ff @(posedge s_clk_50m or posedge s_rst) begin
    if (s_rst) begin
      to_cnt       <= 32'h0;
      acc          <= 32'h0;
      line_tail    <= 32'h0;
      line_len     <= 4'd0;
      line_all_hex <= 1'b1;
    end else begin
      if (accept) begin
        to_cnt       <= 32'h0;
        acc          <= 32'h0;
        line_tail    <= 32'h0;
        line_len     <= 4'd0;
        line_all_hex <= 1'b1;
      end else if (state == RECV) begin
        to_cnt <= to_cnt + 32'd1;
        if (rx_take && !rx_is_cr && !rx_is_lf) begin
          if (line_len != 4'd15) line_len <= line_len + 4'd1;
          line_tail <= {line_tail[23:0], rx_data};
          if (rx_hex_ok) acc <= {acc[27:0], rx_nib};
          else           line_all_hex <= 1'b0;
        end
      end else begin
        to_cnt <= 32'h0;
      end
    end
  end

  // Response registers, updated only when a response is produced.
  always_ff @(posedge s_clk_50m or posedge s_rst) begin
    if (s_rst) begin
      rsp_status <= ST_OK;
      rsp_data   <= 32'h0;
    end else if (timeout_hit) begin
      rsp_status <= ST_TIMEOUT;
      rsp_data   <= 32'h0;
    end else if (line_end) begin
      rsp_status <= line_status;
      rsp_data   <= line_data;
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: a busy-for-N-cycles transmitter model captures
// the command bytes, tasks play device replies, and expected frames and
// responses are queued when stimulus is driven and checked as they appear.
module tb_uart_cmd_master;

  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  logic        s_clk_50m;
  logic        s_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [7:0]  exp_tx_q[$];
  logic [7:0]  got_q[$];
  logic [33:0] exp_q[$];

  int unsigned cyc            = 0;
  int unsigned busy_len       = 10;
  int unsigned busy_cnt       = 0;
  int unsigned last_start_cyc = 0;
  int unsigned n_starts       = 0;

  uart_cmd_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .s_clk_50m  (s_clk_50m),
    .s_rst      (s_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .rsp_data   (rsp_data)
  );

  // clock: 50 MHz
  initial begin
    s_clk_50m = 1'b0;
    forever #10 s_clk_50m = ~s_clk_50m;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

  always @(posedge s_clk_50m) cyc <= cyc + 1;

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge s_clk_50m or posedge s_rst) begin
    if (s_rst) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      got_q.push_back(tx_data);
      busy_cnt       <= busy_len;
      last_start_cyc <= cyc;
      n_starts       <= n_starts + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- driver tasks ----------------

  task automatic drive_request(input logic wr, input logic [7:0] addr,
                               input logic [31:0] data, output bit ok);
    string s;
    if (wr) s = $sformatf("W %h %h", addr, data);
    else    s = $sformatf("R %h", addr);
    s = s.toupper();
    for (int i = 0; i < s.len(); i++) exp_tx_q.push_back(8'(s[i]));
    exp_tx_q.push_back(CR);
    exp_tx_q.push_back(LF);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge s_clk_50m);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_data  = data;
      @(negedge s_clk_50m);
      req_valid = 1'b0;
      req_data  = $urandom;
    end
  endtask

  // Wait for n captured bytes, the last byte to finish, and the reply phase.
  task automatic wait_frame(input int n, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (got_q.size() < n && i < 3000) begin
      @(negedge s_clk_50m);
      i++;
    end
    if (got_q.size() >= n) begin
      i = 0;
      while (tx_busy && i < 200) begin
        @(negedge s_clk_50m);
        i++;
      end
      ok = !tx_busy;
      @(negedge s_clk_50m);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge s_clk_50m);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge s_clk_50m);
    rx_done = 1'b0;
    rx_data = 8'(($urandom_range(0, 255)));
  endtask

  task automatic send_text(input string s);
    for (int i = 0; i < s.len(); i++) send_rx(8'(s[i]));
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    int i;
    i  = 0;
    ok = rsp_valid;
    while (!ok && i < limit) begin
      @(negedge s_clk_50m);
      ok = rsp_valid;
      i++;
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (3) @(negedge s_clk_50m);
    n_checks++;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++;
    if ({rsp_valid, rsp_status, rsp_data} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid %b status %0d data %h want all 0", rsp_valid, rsp_status, rsp_data);
    end
    s_rst = 1'b0;
    @(negedge s_clk_50m);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++;
    if (n_starts != 0) begin n_fail++; $display("FAIL reset_no_start: got %0d tx_start pulses want 0", n_starts); end
  endtask

  task automatic test_write_ok();
    bit ok;
    logic [7:0]  g;
    logic [7:0]  e;
    logic [33:0] x;
    drive_request(1'b1, 8'h1A, 32'hDEADBEEF, ok);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL write_busy_ready: got %b want 0", req_ready); end
    wait_frame(15, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_frame_wait: got %0d bytes want 15", got_q.size()); end
    while (exp_tx_q.size() != 0) begin
      e = exp_tx_q.pop_front();
      if (got_q.size() != 0) g = got_q.pop_front(); else g = 8'h00;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL write_frame_byte: got %h want %h", g, e); end
    end
    exp_q.push_back({2'd0, 32'h0});
    send_text("OK");
    send_rx(CR);
    send_rx(LF);
    x = exp_q.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL write_rsp_latency: rsp_valid got %b want 1", rsp_valid); end
    n_checks++;
    if ({rsp_status, rsp_data} !== x) begin
      n_fail++;
      $display("FAIL write_rsp: got status %0d data %h want status %0d data %h", rsp_status, rsp_data, x[33:32], x[31:0]);
    end
    @(negedge s_clk_50m);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_rsp_pulse: rsp_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_read_ok();
    bit ok;
    logic [7:0]  g;
    logic [7:0]  e;
    logic [33:0] x;
    drive_request(1'b0, 8'h05, 32'hFFFF_FFFF, ok);
    wait_frame(6, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_frame_wait: got %0d bytes want 6", got_q.size()); end
    while (exp_tx_q.size() != 0) begin
      e = exp_tx_q.pop_front();
      if (got_q.size() != 0) g = got_q.pop_front(); else g = 8'h00;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL read_frame_byte: got %h want %h", g, e); end
    end
    exp_q.push_back({2'd0, 32'h0012ABCD});
    send_rx(CR);
    send_rx(LF);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_blank_line: rsp_valid got %b want 0", rsp_valid); end
    send_text("0012abCD");
    send_rx(CR);
    send_rx(LF);
    x = exp_q.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL read_rsp_valid: got %b want 1", rsp_valid); end
    n_checks++;
    if ({rsp_status, rsp_data} !== x) begin
      n_fail++;
      $display("FAIL read_rsp: got status %0d data %h want status %0d data %h", rsp_status, rsp_data, x[33:32], x[31:0]);
    end
    repeat (2) @(negedge s_clk_50m);
    n_checks++;
    if ({rsp_status, rsp_data} !== x) begin
      n_fail++;
      $display("FAIL read_rsp_hold: got status %0d data %h want status %0d data %h", rsp_status, rsp_data, x[33:32], x[31:0]);
    end
  endtask

  // Replies that end in FAIL or a protocol error, from a small table.
  task automatic test_bad_replies();
    bit ok;
    logic        wr;
    string       txt;
    logic [33:0] x;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin wr = 1'b1; txt = "FAIL";  exp_q.push_back({2'd1, 32'h0}); end
        1:       begin wr = 1'b0; txt = "12345"; exp_q.push_back({2'd3, 32'h0}); end
        default: begin wr = 1'b1; txt = "OKX";   exp_q.push_back({2'd3, 32'h0}); end
      endcase
      drive_request(wr, 8'(($urandom_range(0, 255))), $urandom, ok);
      wait_frame(wr ? 15 : 6, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bad_reply_frame_wait: case %0d got %0d bytes", k, got_q.size()); end
      got_q.delete();
      exp_tx_q.delete();
      send_text(txt);
      send_rx(CR);
      send_rx(LF);
      x = exp_q.pop_front();
      n_checks++;
      if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, x}) begin
        n_fail++;
        $display("FAIL bad_reply_rsp: case %0d got valid %b status %0d data %h want valid 1 status %0d data %h",
                 k, rsp_valid, rsp_status, rsp_data, x[33:32], x[31:0]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned r;
    logic [33:0] x;
    drive_request(1'b0, 8'h40, 32'h0, ok);
    wait_frame(6, ok);
    got_q.delete();
    exp_tx_q.delete();
    r = last_start_cyc + busy_len + 2;
    exp_q.push_back({2'd2, 32'h0});
    wait_rsp(1500, ok);
    x = exp_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_no_rsp: rsp_valid never seen within 1500 cycles"); end
    n_checks++;
    if (cyc != r + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: rsp at cycle %0d want %0d", cyc, r + TIMEOUT); end
    n_checks++;
    if ({rsp_status, rsp_data} !== x) begin
      n_fail++;
      $display("FAIL timeout_rsp: got status %0d data %h want status %0d data %h", rsp_status, rsp_data, x[33:32], x[31:0]);
    end
  endtask

  // LF one cycle before expiry succeeds; LF on the expiry cycle times out.
  task automatic test_timeout_lf_race();
    bit ok;
    int unsigned r;
    int unsigned target;
    int i;
    logic [33:0] x;
    for (int k = 0; k < 2; k++) begin
      drive_request(1'b1, 8'h41, 32'h0000_0001, ok);
      wait_frame(15, ok);
      got_q.delete();
      exp_tx_q.delete();
      r = last_start_cyc + busy_len + 2;
      target = (k == 0) ? r + TIMEOUT - 2 : r + TIMEOUT - 1;
      exp_q.push_back((k == 0) ? {2'd0, 32'h0} : {2'd2, 32'h0});
      send_text("OK");
      i = 0;
      while (cyc != target && i < 2000) begin
        @(negedge s_clk_50m);
        i++;
      end
      n_checks++;
      if (cyc != target) begin n_fail++; $display("FAIL lf_race_align: case %0d cycle %0d want %0d", k, cyc, target); end
      rx_done = 1'b1;
      rx_data = LF;
      @(negedge s_clk_50m);
      rx_done = 1'b0;
      x = exp_q.pop_front();
      n_checks++;
      if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, x}) begin
        n_fail++;
        $display("FAIL lf_race_rsp: case %0d got valid %b status %0d want valid 1 status %0d",
                 k, rsp_valid, rsp_status, x[33:32]);
      end
      @(negedge s_clk_50m);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int i;
    int unsigned starts_at;
    logic [7:0]  g;
    logic [7:0]  e;
    logic [33:0] x;
    drive_request(1'b1, 8'h33, 32'h0123_4567, ok);
    i = 0;
    while (got_q.size() < 7 && i < 2000) begin
      @(negedge s_clk_50m);
      i++;
    end
    n_checks++;
    if (got_q.size() < 7) begin n_fail++; $display("FAIL midframe_wait: got %0d bytes want 7", got_q.size()); end
    s_rst     = 1'b1;
    starts_at = n_starts;
    @(negedge s_clk_50m);
    n_checks++;
    if ({tx_start, tx_data} !== 9'h0) begin n_fail++; $display("FAIL midframe_in_reset: tx_start %b tx_data %h want 0", tx_start, tx_data); end
    @(negedge s_clk_50m);
    s_rst = 1'b0;
    repeat (3) @(negedge s_clk_50m);
    n_checks++;
    if (n_starts != starts_at) begin n_fail++; $display("FAIL midframe_tx_stop: got %0d pulses want %0d", n_starts, starts_at); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midframe_ready: got %b want 1", req_ready); end
    got_q.delete();
    exp_tx_q.delete();
    drive_request(1'b1, 8'h34, 32'h89AB_CDEF, ok);
    wait_frame(15, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midframe_refr_wait: got %0d bytes want 15", got_q.size()); end
    while (exp_tx_q.size() != 0) begin
      e = exp_tx_q.pop_front();
      if (got_q.size() != 0) g = got_q.pop_front(); else g = 8'h00;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL midframe_refr_byte: got %h want %h", g, e); end
    end
    exp_q.push_back({2'd0, 32'h0});
    send_text("OK");
    send_rx(CR);
    send_rx(LF);
    x = exp_q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, x}) begin
      n_fail++;
      $display("FAIL midframe_rsp: got valid %b status %0d data %h want status %0d", rsp_valid, rsp_status, rsp_data, x[33:32]);
    end
  endtask

  task automatic test_stray_rx();
    bit ok;
    logic [7:0]  g;
    logic [7:0]  e;
    logic [33:0] x;
    send_text("OK");
    send_rx(LF);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_idle: rsp_valid got %b want 0", rsp_valid); end
    drive_request(1'b0, 8'h77, 32'h0, ok);
    send_text("FA12");
    send_rx(LF);
    send_text("Z9");
    wait_frame(6, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stray_frame_wait: got %0d bytes want 6", got_q.size()); end
    while (exp_tx_q.size() != 0) begin
      e = exp_tx_q.pop_front();
      if (got_q.size() != 0) g = got_q.pop_front(); else g = 8'h00;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL stray_frame_byte: got %h want %h", g, e); end
    end
    exp_q.push_back({2'd0, 32'h89ABCDEF});
    send_text("89abcdef");
    send_rx(CR);
    send_rx(LF);
    x = exp_q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, x}) begin
      n_fail++;
      $display("FAIL stray_rsp: got valid %b status %0d data %h want status %0d data %h",
               rsp_valid, rsp_status, rsp_data, x[33:32], x[31:0]);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    s_rst     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_data  = 32'h0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    test_reset();
    test_write_ok();
    test_read_ok();
    test_bad_replies();
    test_timeout();
    test_timeout_lf_race();
    test_reset_midframe();
    test_stray_rx();
    repeat (5) @(negedge s_clk_50m);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
